// File: rtl/cache_pkg.sv
// Shared widths, line record and backing-store model for the direct-mapped
// instruction-fetch cache.
package cache_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LINES  = 32;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - 2 - IDX_W;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    // The model memory returns the word-aligned address as its contents.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word_addr_s;
        word_addr_s = {addr[ADDR_W-1:2], 2'b00};
        return word_addr_s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/main_cache_if.sv
// Access bus between the address-trace source and the cache: one address in,
// hit/read/data out per clock.
interface main_cache_if;
    import cache_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              hit;
    logic              read;
    logic [DATA_W-1:0] dataOut;

    modport master (output address, input hit, input read, input dataOut);
    modport slave  (input address, output hit, output read, output dataOut);

endinterface

// File: rtl/cache_backing_mem.sv
// Combinational backing-store stand-in; to be swapped for a real memory port.
module cache_backing_mem
    import cache_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    // Deterministic word lookup for miss fills.
    always_comb begin
        data_o = mem_word(addr_i);
    end

endmodule

// File: rtl/main_cache.sv
// Direct-mapped read-only cache: one lookup per edge, misses filled in the
// same cycle from the backing store, registered hit/read/data outputs.
module main_cache
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    main_cache_if.slave  bus
);

    line_t             lines_q [LINES];
    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    line_t             cur_line_s;
    logic              hit_s;
    logic [DATA_W-1:0] mem_data_s;

    logic              hit_d,  hit_q;
    logic              read_d, read_q;
    logic [DATA_W-1:0] data_d, data_q;

    cache_backing_mem u_mem (
        .addr_i (bus.address),
        .data_o (mem_data_s)
    );

    // Address decode and tag compare against the pre-edge line contents.
    always_comb begin
        idx_s      = bus.address[2 +: IDX_W];
        tag_s      = bus.address[ADDR_W-1 -: TAG_W];
        cur_line_s = lines_q[idx_s];
        hit_s      = cur_line_s.valid && (cur_line_s.tag == tag_s);
    end

    // Next output values for the current access.
    always_comb begin
        hit_d  = 1'b0;
        read_d = 1'b0;
        data_d = '0;
        if (hit_s) begin
            hit_d  = 1'b1;
            data_d = cur_line_s.data;
        end else begin
            read_d = 1'b1;
            data_d = mem_data_s;
        end
    end

    // Line array: reset clears only valid bits; a miss overwrites the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                lines_q[i].valid <= 1'b0;
            end
        end else if (!hit_s) begin
            lines_q[idx_s] <= '{valid: 1'b1, tag: tag_s, data: mem_data_s};
        end
    end

    // Registered access result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= 1'b0;
            read_q <= 1'b0;
            data_q <= '0;
        end else begin
            hit_q  <= hit_d;
            read_q <= read_d;
            data_q <= data_d;
        end
    end

    assign bus.hit     = hit_q;
    assign bus.read    = read_q;
    assign bus.dataOut = data_q;

endmodule

// File: tb/tb_main_cache.sv
// Directed bench for main_cache: vector table plus fill/replay, async reset
// and held-address sequences.
module tb_main_cache;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    main_cache_if bus ();

    main_cache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        exp_hit;
        logic        exp_read;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic eh, input logic er, input logic [31:0] ed);
        chk({name, ".hit"},  {31'd0, bus.hit},  {31'd0, eh});
        chk({name, ".read"}, {31'd0, bus.read}, {31'd0, er});
        chk({name, ".data"}, bus.dataOut, ed);
    endtask

    // Drive an address before the edge, sample after it on the falling edge.
    task automatic step(input string name, input logic [31:0] a,
                        input logic eh, input logic er, input logic [31:0] ed);
        bus.address = a;
        @(posedge clk);
        @(negedge clk);
        chk_out(name, eh, er, ed);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.address = 32'h0000_0000;

        vecs[0] = '{32'h0000_0040, 1'b0, 1'b1, 32'h0000_0040};
        vecs[1] = '{32'h0000_0042, 1'b1, 1'b0, 32'h0000_0040};
        vecs[2] = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'h0000_0080, 1'b0, 1'b1, 32'h0000_0080};
        vecs[4] = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
        vecs[5] = '{32'h0000_0043, 1'b1, 1'b0, 32'h0000_0040};
        vecs[6] = '{32'h0000_1043, 1'b0, 1'b1, 32'h0000_1040};
        vecs[7] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFC};
        vecs[8] = '{32'hFFFF_FFFD, 1'b1, 1'b0, 32'hFFFF_FFFC};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 32'h0000_0000);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_hit,
                 vecs[i].exp_read, vecs[i].exp_data);
        end

        do_reset();
        for (int i = 0; i < 32; i++) begin
            step($sformatf("fill%0d", i), 32'(i * 4), 1'b0, 1'b1, 32'(i * 4));
        end
        for (int i = 0; i < 32; i++) begin
            step($sformatf("replay%0d", i), 32'(i * 4), 1'b1, 1'b0, 32'(i * 4));
        end

        // Asynchronous reset between edges right after a hit.
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 32'h0000_007C, 1'b0, 1'b1, 32'h0000_007C);

        step("hold0", 32'h0000_0200, 1'b0, 1'b1, 32'h0000_0200);
        step("hold1", 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0200);
        step("hold2", 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0200);

        bus.address = 32'h0000_0300;
        #2;
        bus.address = 32'h0000_0304;
        #1;
        chk_out("no_edge", 1'b1, 1'b0, 32'h0000_0200);
        step("after_change", 32'h0000_0300, 1'b0, 1'b1, 32'h0000_0300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
